// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and hazard/forwarding response bundle.
// The master side is the ID stage, the slave side is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                      forward_en;
    logic                      issue_valid;
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic                      id_wb_en;
    logic [REG_AW-1:0]         id_dest;
    logic                      id_mem_read;
    logic                      flush;
    logic                      mem_stall;
    logic                      hazard;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic [CNT_W-1:0]          stall_cycles;

    modport master (
        output forward_en, issue_valid, src_addr, src_used,
               id_wb_en, id_dest, id_mem_read, flush, mem_stall,
        input  hazard, fwd_sel, stall_cycles
    );

    modport slave (
        input  forward_en, issue_valid, src_addr, src_used,
               id_wb_en, id_dest, id_mem_read, flush, mem_stall,
        output hazard, fwd_sel, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers between ID and
// write-back, raises the ID stall request and picks a forwarding source per
// operand. Entry 0 is the youngest (EXE), entry DEPTH-1 the oldest.
module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]              r_valid;
    logic [DEPTH-1:0]              r_wb_en;
    logic [DEPTH-1:0]              r_mem_read;
    logic [DEPTH-1:0][REG_AW-1:0]  r_dest;
    logic [CNT_W-1:0]              r_stall_cnt;

    logic [NUM_SRC-1:0][DEPTH-1:0] w_live;
    logic [DEPTH-1:0]              w_unfwd;
    logic                          w_dep_any;
    logic                          w_dep_load;
    logic                          w_hazard;
    logic                          w_issue;
    logic [NUM_SRC*SELW-1:0]       w_fwd_sel;

    // Entries holding a load whose data is still inside the load-to-use window.
    always_comb begin
        w_unfwd = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_unfwd[k] = (k < unsigned'(LOAD_LAT)) & r_mem_read[k];
        end
    end

    // Per source, which tracker entries produce the register it reads.
    always_comb begin
        w_live = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                w_live[i][k] = r_valid[k] & r_wb_en[k] & bus.src_used[i] &
                               (r_dest[k] == bus.src_addr[i*REG_AW +: REG_AW]);
            end
        end
    end

    // Stall request: any dependency without forwarding, only unready loads with it.
    always_comb begin
        w_dep_any  = 1'b0;
        w_dep_load = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_dep_any  = w_dep_any  | (|w_live[i]);
            w_dep_load = w_dep_load | (|(w_live[i] & w_unfwd));
        end
        w_hazard = bus.issue_valid & ~bus.flush &
                   (bus.forward_en ? w_dep_load : w_dep_any);
        w_issue  = bus.issue_valid & ~w_hazard & ~bus.flush;
    end

    // Forward select: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        w_fwd_sel = '0;
        if (bus.forward_en && !w_hazard) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                for (int unsigned k = DEPTH; k > 0; k--) begin
                    if (w_live[i][k-1]) begin
                        w_fwd_sel[i*SELW +: SELW] = SELW'(k);
                    end
                end
            end
        end
    end

    // Tracker shift: frozen on mem_stall, otherwise advance and load ID or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_wb_en    <= '0;
            r_mem_read <= '0;
            r_dest     <= '0;
        end else if (!bus.mem_stall) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_valid[k]    <= r_valid[k-1];
                r_wb_en[k]    <= r_wb_en[k-1];
                r_mem_read[k] <= r_mem_read[k-1];
                r_dest[k]     <= r_dest[k-1];
            end
            r_valid[0]    <= w_issue;
            r_wb_en[0]    <= bus.id_wb_en;
            r_mem_read[0] <= bus.id_mem_read;
            r_dest[0]     <= bus.id_dest;
        end
    end

    // Saturating count of cycles the ID stage was actually held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !bus.mem_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.hazard       = w_hazard;
    assign bus.fwd_sel      = w_fwd_sel;
    assign bus.stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, hand-written corner sequences
// and random stimulus against a queue-based reference model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
    localparam int REG_AW   = 4;
    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 4;
    localparam int SELW     = $clog2(DEPTH + 1);
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
        .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: list of in-flight instructions, youngest first.
    typedef struct {
        bit v;
        bit wb;
        int dest;
        bit ld;
    } ent_t;
    ent_t pipe[$];
    int   m_cnt;

    task automatic model_reset();
        ent_t b;
        b.v = 0; b.wb = 0; b.dest = 0; b.ld = 0;
        pipe.delete();
        for (int k = 0; k < DEPTH; k++) pipe.push_back(b);
        m_cnt = 0;
    endtask

    function automatic bit m_reads(int k, int i);
        int a;
        a = int'(bus.src_addr[i*REG_AW +: REG_AW]);
        return pipe[k].v && pipe[k].wb && bus.src_used[i] && (pipe[k].dest == a);
    endfunction

    function automatic bit m_hazard();
        bit h;
        h = 0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = 0; k < DEPTH; k++)
                if (m_reads(k, i) && (!bus.forward_en || (k < LOAD_LAT && pipe[k].ld))) h = 1;
        return h && bus.issue_valid && !bus.flush;
    endfunction

    function automatic int m_sel(int i);
        if (!bus.forward_en || m_hazard()) return 0;
        for (int k = 0; k < DEPTH; k++)
            if (m_reads(k, i)) return k + 1;
        return 0;
    endfunction

    task automatic model_edge(input bit h);
        ent_t e;
        if (!bus.mem_stall) begin
            e.v    = bus.issue_valid && !h && !bus.flush;
            e.wb   = bus.id_wb_en;
            e.dest = int'(bus.id_dest);
            e.ld   = bus.id_mem_read;
            pipe.push_front(e);
            void'(pipe.pop_back());
            if (h && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit fe, input bit iv, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [1:0] u, input bit wb, input logic [3:0] d, input bit ld,
                         input bit fl, input bit ms);
        bus.forward_en  = fe;
        bus.issue_valid = iv;
        bus.src_addr    = {a1, a0};
        bus.src_used    = u;
        bus.id_wb_en    = wb;
        bus.id_dest     = d;
        bus.id_mem_read = ld;
        bus.flush       = fl;
        bus.mem_stall   = ms;
    endtask

    function automatic int sel_of(int i);
        return int'(bus.fwd_sel[i*SELW +: SELW]);
    endfunction

    // Advance through the active edge, updating the model alongside the DUT.
    task automatic finish_cycle();
        bit h;
        h = m_hazard();
        @(posedge clk);
        model_edge(h);
        #1;
    endtask

    typedef struct {
        bit         fe, iv;
        logic [3:0] a0, a1;
        logic [1:0] u;
        bit         wb;
        logic [3:0] d;
        bit         ld, fl, ms;
        bit         hz;
        int         s0, s1, cnt;
    } vec_t;
    vec_t tbl[16];

    initial begin
        //                fe iv a0    a1    u      wb d     ld fl ms  hz s0 s1 cnt
        tbl[0]  = '{1'b1,1'b1,4'd0,4'd0,2'b00,1'b1,4'd5,1'b1,1'b0,1'b0, 1'b0,0,0,0}; // load r5
        tbl[1]  = '{1'b1,1'b1,4'd5,4'd6,2'b11,1'b1,4'd6,1'b0,1'b0,1'b0, 1'b1,0,0,0}; // load-use stall
        tbl[2]  = '{1'b1,1'b1,4'd5,4'd6,2'b11,1'b1,4'd6,1'b0,1'b0,1'b0, 1'b0,2,0,1}; // fwd from MEM
        tbl[3]  = '{1'b1,1'b1,4'd0,4'd0,2'b00,1'b1,4'd2,1'b0,1'b0,1'b0, 1'b0,0,0,1}; // add r2
        tbl[4]  = '{1'b1,1'b1,4'd2,4'd7,2'b11,1'b1,4'd8,1'b0,1'b0,1'b0, 1'b0,1,0,1}; // ALU fwd
        tbl[5]  = '{1'b0,1'b1,4'd0,4'd0,2'b00,1'b1,4'd4,1'b0,1'b0,1'b0, 1'b0,0,0,1}; // write r4
        tbl[6]  = '{1'b0,1'b1,4'd4,4'd0,2'b01,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b1,0,0,1}; // no-fwd stall 1
        tbl[7]  = '{1'b0,1'b1,4'd4,4'd0,2'b01,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b1,0,0,2}; // no-fwd stall 2
        tbl[8]  = '{1'b0,1'b1,4'd4,4'd0,2'b01,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b0,0,0,3}; // proceeds
        tbl[9]  = '{1'b1,1'b1,4'd0,4'd0,2'b00,1'b1,4'd1,1'b0,1'b0,1'b0, 1'b0,0,0,3}; // write r1 (old)
        tbl[10] = '{1'b1,1'b1,4'd0,4'd0,2'b00,1'b1,4'd1,1'b0,1'b0,1'b0, 1'b0,0,0,3}; // write r1 (new)
        tbl[11] = '{1'b1,1'b1,4'd1,4'd1,2'b11,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b0,1,1,3}; // youngest wins
        tbl[12] = '{1'b1,1'b1,4'd1,4'd1,2'b10,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b0,0,2,3}; // unused src0
        tbl[13] = '{1'b1,1'b1,4'd0,4'd0,2'b00,1'b1,4'd0,1'b1,1'b0,1'b0, 1'b0,0,0,3}; // load r0
        tbl[14] = '{1'b1,1'b1,4'd0,4'd0,2'b01,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b1,0,0,3}; // r0 is a dep
        tbl[15] = '{1'b1,1'b1,4'd0,4'd0,2'b01,1'b0,4'd0,1'b0,1'b0,1'b0, 1'b0,2,0,4}; // fwd r0

        model_reset();
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #12;
        check("reset_hazard", int'(bus.hazard), 0);
        check("reset_fwd_sel", int'(bus.fwd_sel), 0);
        check("reset_stall_cycles", int'(bus.stall_cycles), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        foreach (tbl[n]) begin
            drive(tbl[n].fe, tbl[n].iv, tbl[n].a0, tbl[n].a1, tbl[n].u, tbl[n].wb,
                  tbl[n].d, tbl[n].ld, tbl[n].fl, tbl[n].ms);
            @(negedge clk);
            check($sformatf("tbl%0d_hazard", n), int'(bus.hazard), int'(tbl[n].hz));
            check($sformatf("tbl%0d_sel0", n), sel_of(0), tbl[n].s0);
            check($sformatf("tbl%0d_sel1", n), sel_of(1), tbl[n].s1);
            check($sformatf("tbl%0d_cnt", n), int'(bus.stall_cycles), tbl[n].cnt);
            finish_cycle();
        end

        // Freeze: a pending load-use held for three memory-wait cycles
        drive(1, 1, 0, 0, 2'b00, 1, 5, 1, 0, 0);
        @(negedge clk);
        check("freeze_load_issue", int'(bus.hazard), 0);
        finish_cycle();
        drive(1, 1, 5, 0, 2'b01, 1, 6, 0, 0, 1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("freeze%0d_hazard", n), int'(bus.hazard), 1);
            check($sformatf("freeze%0d_cnt", n), int'(bus.stall_cycles), 4);
            finish_cycle();
        end
        bus.mem_stall = 1'b0;
        @(negedge clk);
        check("thaw_hazard", int'(bus.hazard), 1);
        check("thaw_cnt", int'(bus.stall_cycles), 4);
        finish_cycle();
        @(negedge clk);
        check("thaw_proceed_hazard", int'(bus.hazard), 0);
        check("thaw_proceed_sel0", sel_of(0), 2);
        check("thaw_proceed_cnt", int'(bus.stall_cycles), 5);
        finish_cycle();

        // Flush: killed dependent writes r9; a later reader must not see it
        drive(1, 1, 0, 0, 2'b00, 1, 9, 1, 0, 0);
        finish_cycle();
        drive(1, 1, 9, 0, 2'b01, 1, 9, 0, 1, 0);
        @(negedge clk);
        check("flush_hazard", int'(bus.hazard), 0);
        check("flush_cnt", int'(bus.stall_cycles), 5);
        finish_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("post_flush_hazard", int'(bus.hazard), 0);
        check("post_flush_sel0", sel_of(0), 2);
        check("post_flush_cnt", int'(bus.stall_cycles), 5);
        finish_cycle();

        // Saturation: self-dependent chain without forwarding
        drive(0, 1, 3, 0, 2'b01, 1, 3, 0, 0, 0);
        for (int n = 0; n < 20; n++) finish_cycle();
        @(negedge clk);
        check("sat_hazard", int'(bus.hazard), 1);
        check("sat_cnt", int'(bus.stall_cycles), CNT_MAX);
        finish_cycle();
        @(negedge clk);
        check("sat_nowrap_cnt", int'(bus.stall_cycles), CNT_MAX);
        finish_cycle();

        // Asynchronous reset with live entries in the tracker
        drive(1, 1, 0, 0, 2'b00, 1, 3, 1, 0, 0);
        finish_cycle();
        drive(1, 1, 3, 0, 2'b01, 0, 0, 0, 0, 0);
        #1;
        check("prereset_hazard", int'(bus.hazard), 1);
        rst = 1'b0;
        model_reset();
        #1;
        check("async_reset_hazard", int'(bus.hazard), 0);
        check("async_reset_fwd_sel", int'(bus.fwd_sel), 0);
        check("async_reset_cnt", int'(bus.stall_cycles), 0);
        rst = 1'b1;
        @(negedge clk);
        check("after_reset_r3_hazard", int'(bus.hazard), 0);
        finish_cycle();

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 4) != 0),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 3)), bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 6) == 0));
            @(negedge clk);
            check("rnd_hazard", int'(bus.hazard), int'(m_hazard()));
            check("rnd_sel0", sel_of(0), m_sel(0));
            check("rnd_sel1", sel_of(1), m_sel(1));
            check("rnd_cnt", int'(bus.stall_cycles), m_cnt);
            finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
